// File: rtl/mem_tg_pkg.sv
// Shared types, AXI constants and the beat-pattern function for the memory traffic generator.
package mem_tg_pkg;

  typedef logic [2:0] t_tg_state;

  localparam t_tg_state ST_IDLE    = 3'd0;
  localparam t_tg_state ST_WR_ADDR = 3'd1;
  localparam t_tg_state ST_WR_DATA = 3'd2;
  localparam t_tg_state ST_WR_RESP = 3'd3;
  localparam t_tg_state ST_RD_ADDR = 3'd4;
  localparam t_tg_state ST_RD_DATA = 3'd5;
  localparam t_tg_state ST_DONE    = 3'd6;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned BURST_IDX_W = 16;
  localparam int unsigned BEAT_W      = 8;
  localparam int unsigned GIDX_W      = 24;

  // AXI size encoding for a beat of the given byte width
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

  // Every 32-bit lane of beat g carries seed + g
  function automatic logic [31:0] tg_lane(input logic [31:0] seed, input logic [GIDX_W-1:0] g);
    return seed + 32'(g);
  endfunction

endpackage

// File: rtl/mem_tg_pattern_gen.sv
// Expands seed + global beat index into a full-width data word.
module mem_tg_pattern_gen
  import mem_tg_pkg::*;
#(
  parameter int unsigned DATA_W = 512
) (
  input  logic [31:0]         seed_i,
  input  logic [GIDX_W-1:0]   g_i,
  output logic [DATA_W-1:0]   data_o
);

  localparam int unsigned LANES = DATA_W / 32;

  assign data_o = {LANES{tg_lane(seed_i, g_i)}};

endmodule

// File: rtl/mem_axi_tg_initiator.sv
// AXI4 write-then-readback traffic generator for one memory channel; reports pass/fail and error stats.
module mem_axi_tg_initiator
  import mem_tg_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ID_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [15:0]           cfg_num_bursts,
  input  logic [7:0]            cfg_len,
  input  logic [31:0]           cfg_seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [31:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ID_W-1:0]       awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awlock,
  output logic [2:0]            awprot,
  output logic [3:0]            awqos,
  output logic                  awuser,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  bready,
  input  logic                  bvalid,
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ID_W-1:0]       arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [2:0]            arprot,
  output logic [3:0]            arqos,
  output logic                  aruser,
  output logic                  rready,
  input  logic                  rvalid,
  input  logic [ID_W-1:0]       rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast
);

  localparam int unsigned LANES     = DATA_W / 32;
  localparam int unsigned SIZE_LOG2 = $clog2(DATA_W / 8);
  localparam logic [2:0]  AXI_SIZE  = axi_size(DATA_W / 8);

  t_tg_state                state_q, state_d;
  logic [31:0]              seed_q, seed_d;
  logic [7:0]               len_q, len_d;
  logic [15:0]              nbursts_q, nbursts_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [ADDR_W-1:0]        burst_addr_q, burst_addr_d;
  logic [BURST_IDX_W-1:0]   burst_idx_q, burst_idx_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [GIDX_W-1:0]        g_q, g_d;
  logic [31:0]              err_count_q, err_count_d;
  logic [ADDR_W-1:0]        first_err_addr_q, first_err_addr_d;
  logic                     first_err_seen_q, first_err_seen_d;
  logic                     aborted_q, aborted_d;
  logic                     pass_q, pass_d;
  logic                     done_q, done_d;
  logic                     busy_q, awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
  logic [DATA_W-1:0]        wdata_q;

  logic [DATA_W-1:0]        pat_word;
  logic [DATA_W-1:0]        exp_word;
  logic [ADDR_W-1:0]        stride;
  logic [ADDR_W-1:0]        beat_addr;
  logic                     last_burst;
  logic                     rd_data_err, rd_last_err;
  logic [1:0]               err_inc;
  logic [ADDR_W-1:0]        err_addr;
  logic [32:0]              err_sum;
  logic                     unused_ok;

  // Write data comes from the sub-module; read checking reuses the same lane function
  mem_tg_pattern_gen #(.DATA_W(DATA_W)) u_wr_pattern (
    .seed_i (seed_d),
    .g_i    (g_d),
    .data_o (pat_word)
  );

  assign exp_word    = {LANES{tg_lane(seed_q, g_q)}};
  assign stride      = ADDR_W'({1'b0, len_q} + 9'd1) << SIZE_LOG2;
  assign beat_addr   = burst_addr_q + (ADDR_W'(beat_q) << SIZE_LOG2);
  assign last_burst  = (burst_idx_q == nbursts_q - 16'd1);
  assign rd_data_err = (rdata != exp_word) || (rresp != AXI_RESP_OKAY);
  assign rd_last_err = (rlast != (beat_q == len_q));
  assign unused_ok   = ^{bid, rid};

  // Next-state, counters and checker
  always_comb begin
    state_d          = state_q;
    seed_d           = seed_q;
    len_d            = len_q;
    nbursts_d        = nbursts_q;
    base_d           = base_q;
    burst_addr_d     = burst_addr_q;
    burst_idx_d      = burst_idx_q;
    beat_d           = beat_q;
    g_d              = g_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    first_err_seen_d = first_err_seen_q;
    aborted_d        = aborted_q;
    pass_d           = pass_q;
    done_d           = 1'b0;
    err_inc          = 2'd0;
    err_addr         = beat_addr;
    err_sum          = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          seed_d           = cfg_seed;
          len_d            = cfg_len;
          nbursts_d        = cfg_num_bursts;
          base_d           = cfg_base_addr;
          burst_addr_d     = cfg_base_addr;
          burst_idx_d      = '0;
          beat_d           = '0;
          g_d              = '0;
          err_count_d      = '0;
          first_err_addr_d = '0;
          first_err_seen_d = 1'b0;
          aborted_d        = 1'b0;
          pass_d           = 1'b0;
          state_d          = (cfg_num_bursts == 16'd0) ? ST_DONE : ST_WR_ADDR;
        end
      end
      ST_WR_ADDR: if (awready) state_d = ST_WR_DATA;
      ST_WR_DATA: begin
        if (wready) begin
          g_d = g_q + 24'd1;
          if (beat_q == len_q) begin
            beat_d  = '0;
            state_d = ST_WR_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          if (bresp != AXI_RESP_OKAY) begin
            err_inc  = 2'd1;
            err_addr = burst_addr_q;
          end
          if (abort) begin
            aborted_d = 1'b1;
            state_d   = ST_DONE;
          end else if (last_burst) begin
            burst_idx_d  = '0;
            burst_addr_d = base_q;
            g_d          = '0;
            state_d      = ST_RD_ADDR;
          end else begin
            burst_idx_d  = burst_idx_q + 16'd1;
            burst_addr_d = burst_addr_q + stride;
            state_d      = ST_WR_ADDR;
          end
        end
      end
      ST_RD_ADDR: if (arready) state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (rvalid) begin
          err_inc = 2'(rd_data_err) + 2'(rd_last_err);
          g_d     = g_q + 24'd1;
          // A burst ends on whichever comes first: rlast or the final expected beat
          if (rlast || (beat_q == len_q)) begin
            beat_d = '0;
            if (abort) begin
              aborted_d = 1'b1;
              state_d   = ST_DONE;
            end else if (last_burst) begin
              state_d = ST_DONE;
            end else begin
              burst_idx_d  = burst_idx_q + 16'd1;
              burst_addr_d = burst_addr_q + stride;
              state_d      = ST_RD_ADDR;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_count_q == 32'd0) && !aborted_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Saturating error accumulation; only the first error address is kept
    if (err_inc != 2'd0) begin
      err_sum     = {1'b0, err_count_q} + 33'(err_inc);
      err_count_d = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
      if (!first_err_seen_q) begin
        first_err_seen_d = 1'b1;
        first_err_addr_d = err_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      seed_q           <= '0;
      len_q            <= '0;
      nbursts_q        <= '0;
      base_q           <= '0;
      burst_addr_q     <= '0;
      burst_idx_q      <= '0;
      beat_q           <= '0;
      g_q              <= '0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      first_err_seen_q <= 1'b0;
      aborted_q        <= 1'b0;
      pass_q           <= 1'b0;
      done_q           <= 1'b0;
      busy_q           <= 1'b0;
      awvalid_q        <= 1'b0;
      wvalid_q         <= 1'b0;
      wlast_q          <= 1'b0;
      wdata_q          <= '0;
      bready_q         <= 1'b0;
      arvalid_q        <= 1'b0;
      rready_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      seed_q           <= seed_d;
      len_q            <= len_d;
      nbursts_q        <= nbursts_d;
      base_q           <= base_d;
      burst_addr_q     <= burst_addr_d;
      burst_idx_q      <= burst_idx_d;
      beat_q           <= beat_d;
      g_q              <= g_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_seen_q <= first_err_seen_d;
      aborted_q        <= aborted_d;
      pass_q           <= pass_d;
      done_q           <= done_d;
      busy_q           <= (state_d != ST_IDLE);
      awvalid_q        <= (state_d == ST_WR_ADDR);
      wvalid_q         <= (state_d == ST_WR_DATA);
      wlast_q          <= (state_d == ST_WR_DATA) && (beat_d == len_d);
      wdata_q          <= (state_d == ST_WR_DATA) ? pat_word : '0;
      bready_q         <= (state_d == ST_WR_RESP);
      arvalid_q        <= (state_d == ST_RD_ADDR);
      rready_q         <= (state_d == ST_RD_DATA);
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;

  assign awvalid = awvalid_q;
  assign awid    = '0;
  assign awaddr  = burst_addr_q;
  assign awlen   = len_q;
  assign awsize  = AXI_SIZE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 1'b0;
  assign awprot  = '0;
  assign awqos   = '0;
  assign awuser  = 1'b0;

  assign wvalid = wvalid_q;
  assign wdata  = wdata_q;
  assign wstrb  = '1;
  assign wlast  = wlast_q;
  assign bready = bready_q;

  assign arvalid = arvalid_q;
  assign arid    = '0;
  assign araddr  = burst_addr_q;
  assign arlen   = len_q;
  assign arsize  = AXI_SIZE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 1'b0;
  assign arprot  = '0;
  assign arqos   = '0;
  assign aruser  = 1'b0;
  assign rready  = rready_q;

endmodule

// File: tb/tb_mem_axi_tg_initiator.sv
// Directed bench for mem_axi_tg_initiator with a behavioural AXI memory slave.
module tb_mem_axi_tg_initiator;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 512;
  localparam int unsigned IW = 8;
  localparam int unsigned BY = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start, abort;
  logic [AW-1:0]   cfg_base_addr;
  logic [15:0]     cfg_num_bursts;
  logic [7:0]      cfg_len;
  logic [31:0]     cfg_seed;
  logic            busy, done, pass;
  logic [31:0]     err_count;
  logic [AW-1:0]   first_err_addr;
  logic            awvalid, awready, awlock, awuser;
  logic [IW-1:0]   awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize, awprot;
  logic [1:0]      awburst;
  logic [3:0]      awqos;
  logic            wvalid, wready, wlast;
  logic [DW-1:0]   wdata;
  logic [BY-1:0]   wstrb;
  logic            bready, bvalid;
  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            arvalid, arready, arlock, aruser;
  logic [IW-1:0]   arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize, arprot;
  logic [1:0]      arburst;
  logic [3:0]      arqos;
  logic            rready, rvalid, rlast;
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;

  mem_axi_tg_initiator #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_num_bursts(cfg_num_bursts), .cfg_len(cfg_len), .cfg_seed(cfg_seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awprot(awprot), .awqos(awqos), .awuser(awuser),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bready(bready), .bvalid(bvalid), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arprot(arprot), .arqos(arqos), .aruser(aruser),
    .rready(rready), .rvalid(rvalid), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  int passed = 0;
  int total  = 0;

  // Slave knobs written by the stimulus, counters written only by the slave/monitor
  int dly = 0;
  int corrupt_beat = -1;
  int bad_resp_beat = -1;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int stab_err = 0, proto_err = 0, valid_cyc = 0;
  logic [31:0] aw_log[$];
  logic [31:0] w_lane[$];
  logic [DW-1:0] mem [logic [31:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Write side: AW, W beats into memory, then an OKAY B
  initial begin : slave_wr
    logic [31:0] a;
    logic [7:0] l;
    logic [DW-1:0] d;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    forever begin
      @(negedge clk);
      if (wvalid === 1'b1) proto_err++;
      if (awvalid === 1'b1) begin
        a = awaddr; l = awlen;
        for (int k = 0; k < dly; k++) begin
          @(negedge clk);
          if (awvalid !== 1'b1 || awaddr !== a || awlen !== l || wvalid !== 1'b0) stab_err++;
        end
        awready = 1'b1; aw_cnt++; aw_log.push_back(a);
        @(negedge clk); awready = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
          d = wdata;
          if (wvalid !== 1'b1) proto_err++;
          for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            if (wvalid !== 1'b1 || wdata !== d) stab_err++;
          end
          if (wlast !== (b == int'(l))) proto_err++;
          if (wdata !== {(DW/32){wdata[31:0]}}) proto_err++;
          mem[a + 32'(b * BY)] = wdata;
          w_lane.push_back(wdata[31:0]);
          wready = 1'b1; w_cnt++;
          @(negedge clk); wready = 1'b0;
        end
        if (bready !== 1'b1) proto_err++;
        bvalid = 1'b1; b_cnt++;
        @(negedge clk); bvalid = 1'b0;
      end
    end
  end

  // Read side: AR, then stream memory back with optional corruption / bad response
  initial begin : slave_rd
    logic [31:0] a;
    logic [7:0] l;
    logic [DW-1:0] d;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0; rid = '0;
    forever begin
      @(negedge clk);
      if (arvalid === 1'b1) begin
        a = araddr; l = arlen;
        for (int k = 0; k < dly; k++) begin
          @(negedge clk);
          if (arvalid !== 1'b1 || araddr !== a || arlen !== l) stab_err++;
        end
        arready = 1'b1; ar_cnt++;
        @(negedge clk); arready = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
          d = mem.exists(a + 32'(b * BY)) ? mem[a + 32'(b * BY)] : '0;
          if (r_cnt == corrupt_beat) d[7:0] = d[7:0] ^ 8'hFF;
          rresp = (r_cnt == bad_resp_beat) ? 2'b10 : 2'b00;
          if (rready !== 1'b1) proto_err++;
          rdata = d; rlast = (b == int'(l)); rvalid = 1'b1; r_cnt++;
          @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    if (awvalid === 1'b1 || wvalid === 1'b1 || arvalid === 1'b1) valid_cyc++;
  end

  task automatic kick(input logic [31:0] base, input logic [15:0] nb, input logic [7:0] len,
                      input logic [31:0] seed);
    cfg_base_addr = base; cfg_num_bursts = nb; cfg_len = len; cfg_seed = seed;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    logic seen;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 4000) begin
      @(posedge clk); #1; cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin : stim
    int cyc, aw0, w0, b0, ar0, r0, v0, l0;
    start = 1'b0; abort = 1'b0;
    cfg_base_addr = '0; cfg_num_bursts = '0; cfg_len = '0; cfg_seed = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    check("const_awsize", 64'(awsize), 64'd6);
    check("const_arburst", 64'(arburst), 64'd1);
    check("const_wstrb", 64'(wstrb), 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk); rst_n = 1'b1;

    // 1: ideal slave, two bursts of four beats
    aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt; r0 = r_cnt; l0 = aw_log.size();
    kick(32'h0, 16'd2, 8'd3, 32'h100);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done(cyc);
    check("t1_pass", 64'(pass), 64'd1);
    check("t1_err", 64'(err_count), 64'd0);
    check("t1_aw_cnt", 64'(aw_cnt - aw0), 64'd2);
    check("t1_w_cnt", 64'(w_cnt - w0), 64'd8);
    check("t1_r_cnt", 64'(r_cnt - r0), 64'd8);
    check("t1_awaddr0", 64'(aw_log[l0]), 64'h0);
    check("t1_awaddr1", 64'(aw_log[l0 + 1]), 64'h100);
    for (int i = 0; i < 8; i++) check("t1_wlane", 64'(w_lane[w0 + i]), 64'(32'h100 + 32'(i)));

    // 2: read beat 5 (address 0x140) corrupted
    corrupt_beat = r_cnt + 5;
    kick(32'h0, 16'd2, 8'd3, 32'h100);
    wait_done(cyc);
    corrupt_beat = -1;
    check("t2_err", 64'(err_count), 64'd1);
    check("t2_first_addr", 64'(first_err_addr), 64'h140);
    check("t2_pass", 64'(pass), 64'd0);

    // 3: ready signals held low for 10 cycles per handshake
    dly = 10;
    aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt; r0 = r_cnt;
    kick(32'h0, 16'd2, 8'd3, 32'h100);
    wait_done(cyc);
    dly = 0;
    check("t3_pass", 64'(pass), 64'd1);
    check("t3_err", 64'(err_count), 64'd0);
    check("t3_aw_cnt", 64'(aw_cnt - aw0), 64'd2);
    check("t3_ar_cnt", 64'(ar_cnt - ar0), 64'd2);
    check("t3_w_cnt", 64'(w_cnt - w0), 64'd8);
    check("t3_stable", 64'(stab_err), 64'd0);

    // 4: empty test, done two cycles after start
    v0 = valid_cyc;
    kick(32'h0, 16'd0, 8'd3, 32'h100);
    check("t4_busy_in_done", 64'(busy), 64'd1);
    check("t4_no_early_done", 64'(done), 64'd0);
    wait_done(cyc);
    check("t4_done_latency", 64'(cyc + 1), 64'd2);
    check("t4_pass", 64'(pass), 64'd1);
    check("t4_no_valids", 64'(valid_cyc - v0), 64'd0);

    // 5: abort during beat 2 of write burst 0
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt;
    kick(32'h1000, 16'd2, 8'd7, 32'hA5A5_0000);
    cyc = 0;
    while (w_cnt - w0 < 2 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("t5_reached_beat2", 64'(w_cnt - w0 >= 2), 64'd1);
    abort = 1'b1;
    wait_done(cyc);
    abort = 1'b0;
    check("t5_pass", 64'(pass), 64'd0);
    check("t5_err", 64'(err_count), 64'd0);
    check("t5_aw_cnt", 64'(aw_cnt - aw0), 64'd1);
    check("t5_w_cnt", 64'(w_cnt - w0), 64'd8);
    check("t5_b_cnt", 64'(b_cnt - b0), 64'd1);
    check("t5_no_ar", 64'(ar_cnt - ar0), 64'd0);

    // 6: address wrap and a bad read response on beat 1
    l0 = aw_log.size();
    bad_resp_beat = r_cnt + 1;
    kick(32'hFFFF_FF80, 16'd2, 8'd1, 32'h0000_0042);
    wait_done(cyc);
    bad_resp_beat = -1;
    check("t6_awaddr0", 64'(aw_log[l0]), 64'hFFFF_FF80);
    check("t6_awaddr_wrap", 64'(aw_log[l0 + 1]), 64'h0);
    check("t6_err", 64'(err_count), 64'd1);
    check("t6_first_addr", 64'(first_err_addr), 64'hFFFF_FFC0);
    check("t6_pass", 64'(pass), 64'd0);

    check("protocol_errors", 64'(proto_err), 64'd0);
    check("stability_errors", 64'(stab_err), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
